// File: rtl/reduc_share_arb_pkg.sv
// Shared constants for the reduction-core arbiter and its picker.
package reduc_share_arb_pkg;

    // Modulus and default interface of the shared reduction core.
    localparam int unsigned Q          = 33292289;
    localparam int unsigned RED_DIN_W  = 50;
    localparam int unsigned RED_DOUT_W = 25;
    localparam int unsigned RED_LAT    = 3;

    // Index width for n requesters (clog2, never below 1).
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'(1) << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reduc_share_arb_rr_pick.sv
// Round-robin picker: rotate eligible by ptr, take lowest set bit, rotate back.
module reduc_share_arb_rr_pick
    import reduc_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;

    // Search starts at ptr and wraps; result is mapped back to an absolute index.
    always_comb begin
        rot   = N_REQ'({elig_i, elig_i} >> ptr_i);
        off   = '0;
        any_o = 1'b0;
        for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off   = ID_W'(j);
                any_o = 1'b1;
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_REQ)) begin
            sum = sum - (ID_W+1)'(N_REQ);
        end
        idx_o = sum[ID_W-1:0];
        gnt_o = '0;
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/reduc_share_arb.sv
// Round-robin sharing of one pipelined modular reduction core among N_REQ lanes.
module reduc_share_arb
    import reduc_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_W   = id_width(N_REQ),
    parameter int unsigned LAT    = RED_LAT,
    parameter int unsigned DIN_W  = RED_DIN_W,
    parameter int unsigned DOUT_W = RED_DOUT_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DIN_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         cfg_mask,
    input  logic                     hold,
    output logic                     core_en,
    output logic [DIN_W-1:0]         core_din,
    input  logic [DOUT_W-1:0]        core_dout,
    output logic [N_REQ-1:0]         res_valid,
    output logic [DOUT_W-1:0]        res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy,
    output logic [N_REQ*CNT_W-1:0]   done_cnt
);

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;

    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic                         core_en_q, core_en_d;
    logic [DIN_W-1:0]             core_din_q, core_din_d;
    logic [ID_W-1:0]              id_q, id_d;
    logic [LAT-1:0]               tag_v_q, tag_v_d;
    logic [LAT-1:0][ID_W-1:0]     tag_id_q, tag_id_d;
    logic [N_REQ-1:0]             res_valid_q, res_valid_d;
    logic [DOUT_W-1:0]            res_data_q, res_data_d;
    logic [ID_W-1:0]              res_id_q, res_id_d;
    logic [N_REQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    // No transfer is offered while held or while reset is asserted.
    assign eligible = (req_valid & cfg_mask) & {N_REQ{~hold & rst}};

    reduc_share_arb_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .elig_i (eligible),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // Next state: issue regs, tag shift register, result stage, counters.
    always_comb begin
        ptr_d       = ptr_q;
        core_en_d   = gnt_any;
        core_din_d  = core_din_q;
        id_d        = id_q;
        res_valid_d = '0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        if (gnt_any) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (gnt_idx == ID_W'(i)) begin
                    core_din_d = req_data[i*DIN_W +: DIN_W];
                end
            end
            id_d  = gnt_idx;
            ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        tag_v_d[0]  = core_en_q;
        tag_id_d[0] = id_q;
        for (int s = 1; s < int'(LAT); s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end

        // Last tag stage lines up with core_dout.
        if (tag_v_q[LAT-1]) begin
            res_valid_d[tag_id_q[LAT-1]] = 1'b1;
            res_data_d                   = core_dout;
            res_id_d                     = tag_id_q[LAT-1];
        end

        for (int i = 0; i < int'(N_REQ); i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(res_valid_q[i]);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            core_en_q   <= 1'b0;
            core_din_q  <= '0;
            id_q        <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            core_en_q   <= core_en_d;
            core_din_q  <= core_din_d;
            id_q        <= id_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = gnt;
    assign core_en   = core_en_q;
    assign core_din  = core_din_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign done_cnt  = cnt_q;
    assign busy      = (|tag_v_q) | core_en_q | (|eligible);

endmodule

// File: tb/tb_reduc_share_arb.sv
// Randomized and directed bench for reduc_share_arb with a queue-based reference model.
module tb_reduc_share_arb;
    import reduc_share_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 3;
    localparam int DW  = 50;
    localparam int OW  = 25;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    cfg_mask = '1;
    logic            hold = 1'b0;
    logic            core_en;
    logic [DW-1:0]   core_din;
    logic [OW-1:0]   core_dout;
    logic [N-1:0]    res_valid;
    logic [OW-1:0]   res_data;
    logic [IDW-1:0]  res_id;
    logic            busy;
    logic [N*CW-1:0] done_cnt;

    reduc_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_mask  (cfg_mask),
        .hold      (hold),
        .core_en   (core_en),
        .core_din  (core_din),
        .core_dout (core_dout),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [OW-1:0] val;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] dat [N];
    logic [CW-1:0] exp_cnt [N];
    int            ptr_m = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OW-1:0] red(input logic [DW-1:0] x);
        return OW'(x % DW'(Q));
    endfunction

    function automatic logic [DW-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return DW'(Q - 1);
            1:       return DW'(Q);
            2:       return '1;
            default: return DW'(r);
        endcase
    endfunction

    // Reduction core stand-in: fixed latency, junk when not fed, never reset.
    logic [OW-1:0] pipe [LAT];
    initial for (int s = 0; s < LAT; s++) pipe[s] = 25'h1ABCDE;
    assign core_dout = pipe[LAT-1];
    always @(posedge clk) begin
        pipe[0] <= core_en ? red(core_din) : 25'h1ABCDE;
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end

    // Scoreboard: every result must match the oldest outstanding issue, on time.
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] oh;
        if (res_valid !== '0) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL res_unexpected: got valid=%b id=%0d data=%0d, want no result", res_valid, res_id, res_data);
            end else begin
                e = q.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                if (res_valid !== oh || res_id !== IDW'(e.id) || res_data !== e.val || cyc != e.due) begin
                    n_err++;
                    $display("FAIL res_match: got valid=%b id=%0d data=%0d cyc=%0d, want valid=%b id=%0d data=%0d cyc=%0d",
                             res_valid, res_id, res_data, cyc, oh, e.id, e.val, e.due);
                end
                exp_cnt[e.id] = exp_cnt[e.id] + 1'b1;
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL res_missing: got no result at cyc=%0d, want id=%0d data=%0d", cyc, q[0].id, q[0].val);
            void'(q.pop_front());
        end
    end

    // Drive one cycle of inputs and advance the arbitration model; g = expected grant or -1.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N-1:0] m, input logic h, output int g);
        exp_t e;
        @(negedge clk);
        #1;
        req_valid = v;
        cfg_mask  = m;
        hold      = h;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
        #1;
        g = -1;
        if (!h) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (g < 0 && v[c] && m[c]) g = c;
            end
        end
        if (g >= 0) begin
            e.id  = g;
            e.val = red(dat[g]);
            e.due = cyc + LAT + 2;
            q.push_back(e);
            ptr_m = (g + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
        hold = 1'b0;
        q.delete();
        ptr_m = 0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results outstanding, want 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        @(negedge clk);
        #1;
        req_valid = '1;
        cfg_mask  = '1;
        #1;
        n_cmp++;
        if (req_ready !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got ready=%b busy=%b, want 0000 0", req_ready, busy);
        end
        do_reset();
        #1;
        n_cmp++;
        if (core_en !== 1'b0 || core_din !== '0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_issue: got en=%b din=%0d ready=%b, want 0 0 0000", core_en, core_din, req_ready);
        end
        n_cmp++;
        if (res_valid !== '0 || res_data !== '0 || res_id !== '0) begin
            n_err++;
            $display("FAIL reset_res: got valid=%b data=%0d id=%0d, want 0 0 0", res_valid, res_data, res_id);
        end
        n_cmp++;
        if (busy !== 1'b0 || done_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got busy=%b cnt=%h, want 0 0", busy, done_cnt);
        end
    endtask

    task automatic test_all_four();
        int g;
        int t;
        logic [N-1:0] pend;
        logic [N-1:0] want;
        logic [OW-1:0] want_d [N];
        want_d[0] = 25'd100;
        want_d[1] = 25'd0;
        want_d[2] = 25'd7;
        want_d[3] = 25'd33292288;
        dat[0] = 50'd100;
        dat[1] = 50'd33292289;
        dat[2] = 50'd166461452;
        dat[3] = 50'd33292288;
        pend = '1;
        for (int k = 0; k < N; k++) begin
            drive_cycle(pend, '1, 1'b0, g);
            want = '0;
            want[k] = 1'b1;
            n_cmp++;
            if (req_ready !== want) begin
                n_err++;
                $display("FAIL four_grant%0d: got %b want %b", k, req_ready, want);
            end
            if (g >= 0) pend[g] = 1'b0;
            if (k == 1) begin
                n_cmp++;
                if (core_en !== 1'b1 || core_din !== 50'd100) begin
                    n_err++;
                    $display("FAIL four_core: got en=%b din=%0d, want 1 100", core_en, core_din);
                end
            end
        end
        drive_cycle('0, '1, 1'b0, g);
        t = 0;
        while (res_valid === '0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < N; k++) begin
            want = '0;
            want[k] = 1'b1;
            n_cmp++;
            if (res_valid !== want || res_data !== want_d[k]) begin
                n_err++;
                $display("FAIL four_res%0d: got %b/%0d want %b/%0d", k, res_valid, res_data, want, want_d[k]);
            end
            @(negedge clk);
        end
        drain();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (done_cnt[i*CW +: CW] !== 16'd1) begin
                n_err++;
                $display("FAIL four_cnt%0d: got %0d want 1", i, done_cnt[i*CW +: CW]);
            end
        end
    endtask

    task automatic test_single();
        int g;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            dat[2] = rand_op();
            drive_cycle(4'b0100, '1, 1'b0, g);
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_err++;
                $display("FAIL single_grant%0d: got %b want 0100", k, req_ready);
            end
        end
        drive_cycle('0, '1, 1'b0, g);
        drain();
        n_cmp++;
        if (done_cnt !== {16'd0, 16'd10, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL single_cnt: got %h want 0000000a00000000", done_cnt);
        end
    endtask

    task automatic test_mask();
        int g;
        int seq [6];
        logic [N-1:0] want;
        seq = '{0, 1, 3, 0, 1, 3};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) dat[i] = rand_op();
            drive_cycle('1, 4'b1011, 1'b0, g);
            want = '0;
            want[seq[k]] = 1'b1;
            n_cmp++;
            if (req_ready !== want) begin
                n_err++;
                $display("FAIL mask_grant%0d: got %b want %b", k, req_ready, want);
            end
        end
        drive_cycle('0, '1, 1'b0, g);
        drain();
        n_cmp++;
        if (done_cnt !== {16'd2, 16'd0, 16'd2, 16'd2}) begin
            n_err++;
            $display("FAIL mask_cnt: got %h want 0002000000020002", done_cnt);
        end
    endtask

    task automatic test_hold();
        int g;
        int seen;
        int saved;
        logic [N-1:0] want;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) dat[i] = rand_op();
            drive_cycle('1, '1, 1'b0, g);
        end
        saved = ptr_m;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            drive_cycle('1, '1, 1'b1, g);
            if (res_valid !== '0) seen++;
            n_cmp++;
            if (req_ready !== '0) begin
                n_err++;
                $display("FAIL hold_ready%0d: got %b want 0000", k, req_ready);
            end
            if (k > 0) begin
                n_cmp++;
                if (core_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_core%0d: got %b want 0", k, core_en);
                end
            end
        end
        n_cmp++;
        if (seen != 3) begin
            n_err++;
            $display("FAIL hold_results: got %0d results during hold, want 3", seen);
        end
        drive_cycle('1, '1, 1'b0, g);
        want = '0;
        want[saved] = 1'b1;
        n_cmp++;
        if (req_ready !== want || core_en !== 1'b0) begin
            n_err++;
            $display("FAIL hold_resume: got ready=%b en=%b, want %b 0", req_ready, core_en, want);
        end
        drive_cycle('0, '1, 1'b0, g);
        drain();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_idle: got %b want 0", busy);
        end
        drive_cycle('1, '1, 1'b1, g);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_held: got %b want 0", busy);
        end
        drive_cycle(4'b0010, '1, 1'b0, g);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_pending: got %b want 1", busy);
        end
        drive_cycle('0, '1, 1'b0, g);
        drain();
    endtask

    task automatic test_random();
        int g;
        int prev_g;
        logic [DW-1:0] prev_d;
        logic [N-1:0] v;
        logic [N-1:0] m;
        logic [N-1:0] want;
        prev_g = -1;
        prev_d = '0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) dat[i] = rand_op();
            v = N'($urandom);
            m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            drive_cycle(v, m, ($urandom_range(0, 9) == 0), g);
            want = '0;
            if (g >= 0) want[g] = 1'b1;
            n_cmp++;
            if (req_ready !== want) begin
                n_err++;
                $display("FAIL rand_grant%0d: got %b want %b", k, req_ready, want);
            end
            if (k > 0) begin
                n_cmp++;
                if (core_en !== (prev_g >= 0) || (prev_g >= 0 && core_din !== prev_d)) begin
                    n_err++;
                    $display("FAIL rand_core%0d: got en=%b din=%0d, want en=%b din=%0d", k, core_en, core_din, (prev_g >= 0), prev_d);
                end
            end
            prev_g = g;
            if (g >= 0) prev_d = dat[g];
        end
        drive_cycle('0, '1, 1'b0, g);
        drain();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (done_cnt[i*CW +: CW] !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL rand_cnt%0d: got %0d want %0d", i, done_cnt[i*CW +: CW], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) dat[i] = rand_op();
            drive_cycle('1, '1, 1'b0, g);
        end
        drive_cycle('0, '1, 1'b0, g);
        @(negedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ptr_m = 0;
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (core_en !== 1'b0 || core_din !== '0 || res_valid !== '0 || res_data !== '0 ||
            res_id !== '0 || busy !== 1'b0 || done_cnt !== '0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL midrst_zero: got en=%b din=%0d rv=%b rd=%0d rid=%0d busy=%b cnt=%h, want all 0",
                     core_en, core_din, res_valid, res_data, res_id, busy, done_cnt);
        end
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (res_valid !== '0) begin
                n_err++;
                $display("FAIL midrst_stale%0d: got %b want 0000", k, res_valid);
            end
        end
    endtask

    task automatic test_wrap();
        int g;
        exp_cnt[0] = 16'hFFFF;
        @(negedge clk);
        force dut.cnt_q = {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
        @(negedge clk);
        release dut.cnt_q;
        dat[0] = rand_op();
        drive_cycle(4'b0001, '1, 1'b0, g);
        drive_cycle('0, '1, 1'b0, g);
        drain();
        n_cmp++;
        if (done_cnt[CW-1:0] !== 16'd0) begin
            n_err++;
            $display("FAIL wrap_cnt0: got %0d want 0", done_cnt[CW-1:0]);
        end
        for (int i = 1; i < N; i++) begin
            n_cmp++;
            if (done_cnt[i*CW +: CW] !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL wrap_cnt%0d: got %0d want %0d", i, done_cnt[i*CW +: CW], exp_cnt[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) dat[i] = '0;
        test_reset();
        test_all_four();
        test_single();
        test_mask();
        test_hold();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
